alu_exec_stage: RTL
===================

Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the 64-bit register bank.
- Consumes the two read operands plus an opcode and destination index. Computes a 64-bit result and drives the bank's write port (WriteRegister, WriteData, RegWrite).
- Single-cycle ops complete in one clock. MUL uses an iterative shift-add unit. A valid/ready handshake stalls the issuing logic while the unit is busy.

Parameters:
- WIDTH, 64, operand/result width in bits.
- REG_ADDR_W, 5, register index width (32 registers).
- MUL_CYCLES, 64, iterations of the multiplier; equals WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  synchronous active-low reset.
- InValid  input  1  operation offered this cycle.
- InReady  output  1  stage can accept; transfer occurs when InValid && InReady at a rising edge.
- OperandA  input  WIDTH  first operand (bank ReadData1).
- OperandB  input  WIDTH  second operand (bank ReadData2); low 6 bits are the shift amount for shifts.
- AluOp  input  4  opcode, encodings from alu_pkg.
- DestReg  input  REG_ADDR_W  destination register index.
- WriteRegister  output  REG_ADDR_W  to bank write address.
- WriteData  output  WIDTH  to bank write data.
- RegWrite  output  1  one-cycle write strobe to bank.
- Zero  output  1  WriteData == 0, valid while RegWrite=1.
- IllegalOp  output  1  one-cycle pulse for an undefined opcode.
- Busy  output  1  multiplier iterating.

Behaviour:
- Reset (Rst_n=0 at an edge):
  - state=IDLE.
  - WriteRegister=0, WriteData=0, RegWrite=0, Zero=0, IllegalOp=0, Busy=0.
  - Multiplier counter and accumulators cleared.
  - Reset mid-MUL aborts the operation with no write.
- States: IDLE, MUL, WB.
- InReady=1 in IDLE and WB, 0 in MUL.
- Single-cycle ops:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLL=7, SRL=8, SRA=9.
  - Accepted at edge k: outputs registered at edge k+1, state WB, RegWrite=1 for exactly that cycle.
  - Arithmetic wraps mod 2^64; there is no overflow flag.
  - SLT is signed and produces 1 or 0.
  - Shift amount is OperandB[5:0]; SRA is arithmetic.
- MUL (opcode 10):
  - Accepted at edge k: the operands are latched, state MUL, Busy=1.
  - One shift-add iteration per cycle, MUL_CYCLES iterations. Result is the low 64 bits of the unsigned product, which equals the two's-complement low half.
  - At edge k+64: result registered, state WB, RegWrite=1, Busy=0.
  - InValid is ignored during MUL and no new operation is accepted.
- Opcodes 11-15: accepted, no write. At edge k+1: IllegalOp=1, RegWrite=0, state WB.
- WB:
  - If InValid, the new op is accepted at the same edge, so back-to-back single-cycle ops give a write every cycle.
  - Otherwise the next state is IDLE and RegWrite drops to 0.
- WriteRegister/WriteData/Zero hold their last values when RegWrite=0.
- DestReg=0 is written like any other register; the bank has no hardwired zero.
- Operands and DestReg are sampled only at the accept edge; later changes have no effect.

Decomposition:
- alu_pkg:
  - AluOp localparams (ALU_ADD … ALU_MUL).
  - State encodings.
  - WIDTH/REG_ADDR_W defaults.
- Sub-module alu_mul_iter holds the iterative multiplier:
  - Ports: start, a, b → done, product.
  - Contains its own 6-bit counter.
  - alu_exec_stage instantiates it and hosts the FSM plus the combinational single-cycle datapath.

Test Plan:
- ADD: A=64'hFFFF_FFFF_FFFF_FFFF, B=1, DestReg=7 → next cycle RegWrite=1, WriteRegister=7, WriteData=0, Zero=1.
- Back-to-back: SUB A=10 B=3 (→7), then SLT A=-1 B=1 (→1), then SRA A=64'h8000_0000_0000_0000 B=4 (→64'hF800_0000_0000_0000) → RegWrite high three consecutive cycles with those values.
- MUL: A=64'h1_0000_0001, B=3, DestReg=31 → InReady=0 and Busy=1 for 64 cycles; RegWrite pulses exactly at edge k+64 with WriteData=64'h3_0000_0003; InValid pulses during MUL are ignored.
- Illegal opcode 13 → IllegalOp=1 for one cycle, RegWrite stays 0, InReady high the next cycle.
- Rst_n low at MUL iteration 30 → no RegWrite ever produced for that op; all outputs 0 next cycle; a subsequent ADD 2+2 writes 4 one cycle after accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM states, defaults.
package alu_pkg;

  localparam int DEF_WIDTH      = 64;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_MUL_CYCLES = 64;
  localparam int OP_W           = 4;

  localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [OP_W-1:0] ALU_NOR = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLT = 4'd6;
  localparam logic [OP_W-1:0] ALU_SLL = 4'd7;
  localparam logic [OP_W-1:0] ALU_SRL = 4'd8;
  localparam logic [OP_W-1:0] ALU_SRA = 4'd9;
  localparam logic [OP_W-1:0] ALU_MUL = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Opcodes that finish in one clock through the combinational datapath.
  function automatic logic is_single_cycle(input logic [OP_W-1:0] op);
    return (op <= ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, low WIDTH
// bits of the unsigned product (identical to the two's-complement low half).
// done is asserted combinationally during the final iteration so the caller
// can register product on the same edge the last add completes.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             run_r;
  logic [WIDTH-1:0] acc_nxt_s;

  // Accumulator after adding the current partial product.
  always_comb begin
    acc_nxt_s = acc_r;
    if (mplier_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  assign done    = run_r && (cnt_r == CNT_LAST);
  assign product = acc_nxt_s;

  // Latch operands on start, then shift-add once per clock until the last iteration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      run_r    <= 1'b0;
    end else if (start) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= '0;
      cnt_r    <= '0;
      run_r    <= 1'b1;
    end else if (run_r) begin
      acc_r    <= acc_nxt_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + 1'b1;
      if (cnt_r == CNT_LAST) begin
        run_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage behind the register bank: single-cycle ALU ops, an iterative
// multiplier and a valid/ready handshake; drives the bank write port.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [WIDTH-1:0]      OperandA,
  input  logic [WIDTH-1:0]      OperandB,
  input  logic [OP_W-1:0]       AluOp,
  input  logic [REG_ADDR_W-1:0] DestReg,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [WIDTH-1:0]      WriteData,
  output logic                  RegWrite,
  output logic                  Zero,
  output logic                  IllegalOp,
  output logic                  Busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_e                state_r;
  state_e                state_nxt_s;
  logic [REG_ADDR_W-1:0] mul_dest_r;
  logic [SHAMT_W-1:0]    shamt_s;
  logic [WIDTH-1:0]      alu_res_s;
  logic                  accept_s;
  logic                  mul_start_s;
  logic                  mul_done_s;
  logic [WIDTH-1:0]      mul_prod_s;
  logic                  load_s;
  logic [WIDTH-1:0]      res_nxt_s;
  logic [REG_ADDR_W-1:0] dest_nxt_s;
  logic                  wr_nxt_s;
  logic                  ill_nxt_s;

  assign InReady  = (state_r != ST_MUL);
  assign accept_s = InValid && InReady;
  assign shamt_s  = OperandB[SHAMT_W-1:0];

  alu_mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .start   (mul_start_s),
    .a       (OperandA),
    .b       (OperandB),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // Single-cycle datapath; unused opcodes yield zero.
  always_comb begin
    alu_res_s = '0;
    case (AluOp)
      ALU_ADD: alu_res_s = OperandA + OperandB;
      ALU_SUB: alu_res_s = OperandA - OperandB;
      ALU_AND: alu_res_s = OperandA & OperandB;
      ALU_OR:  alu_res_s = OperandA | OperandB;
      ALU_XOR: alu_res_s = OperandA ^ OperandB;
      ALU_NOR: alu_res_s = ~(OperandA | OperandB);
      ALU_SLT: alu_res_s = ($signed(OperandA) < $signed(OperandB)) ?
                           {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      ALU_SLL: alu_res_s = OperandA << shamt_s;
      ALU_SRL: alu_res_s = OperandA >> shamt_s;
      ALU_SRA: alu_res_s = $signed(OperandA) >>> shamt_s;
      default: alu_res_s = '0;
    endcase
  end

  // Next-state and next-output decisions for IDLE/MUL/WB.
  always_comb begin
    state_nxt_s = state_r;
    mul_start_s = 1'b0;
    load_s      = 1'b0;
    res_nxt_s   = alu_res_s;
    dest_nxt_s  = DestReg;
    wr_nxt_s    = 1'b0;
    ill_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_WB: begin
        if (accept_s) begin
          if (is_single_cycle(AluOp)) begin
            state_nxt_s = ST_WB;
            load_s      = 1'b1;
            wr_nxt_s    = 1'b1;
          end else if (AluOp == ALU_MUL) begin
            state_nxt_s = ST_MUL;
            mul_start_s = 1'b1;
          end else begin
            state_nxt_s = ST_WB;
            ill_nxt_s   = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_nxt_s = ST_WB;
          load_s      = 1'b1;
          wr_nxt_s    = 1'b1;
          res_nxt_s   = mul_prod_s;
          dest_nxt_s  = mul_dest_r;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Hold the destination of an in-flight multiply; later DestReg changes are ignored.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      mul_dest_r <= '0;
    end else if (mul_start_s) begin
      mul_dest_r <= DestReg;
    end
  end

  // Registered write-port outputs; data/address/zero hold unless a write is produced.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      WriteRegister <= '0;
      WriteData     <= '0;
      RegWrite      <= 1'b0;
      Zero          <= 1'b0;
      IllegalOp     <= 1'b0;
      Busy          <= 1'b0;
    end else begin
      RegWrite  <= wr_nxt_s;
      IllegalOp <= ill_nxt_s;
      Busy      <= (state_nxt_s == ST_MUL);
      if (load_s) begin
        WriteRegister <= dest_nxt_s;
        WriteData     <= res_nxt_s;
        Zero          <= (res_nxt_s == '0);
      end
    end
  end

endmodule
